// File: rtl/slow_clock_monitor.sv
// Samples a divided slow clock in the CLOCK_50 domain, emits rising-edge TICK strobes,
// measures each half-period and tracks lock / loss / fault status.
module slow_clock_monitor #(
    parameter int unsigned EXPECT_HALF = 5000001,
    parameter int unsigned TOL         = 16,
    parameter int unsigned LOCK_N      = 4,
    parameter int unsigned TIMEOUT     = 10000002,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             SLOW_IN,
    output logic             TICK,
    output logic [CNT_W-1:0] HALF_PERIOD,
    output logic             LOCKED,
    output logic             FAULT,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCK    = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam int unsigned      RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HALF_LO  = CNT_W'(EXPECT_HALF - TOL);
    localparam logic [CNT_W-1:0] HALF_HI  = CNT_W'(EXPECT_HALF + TOL);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

    logic             s1, s2, s3;
    logic             rise, slow_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic             good, timeout;
    logic [RUN_W-1:0] run, run_nxt, run_inc;
    logic             fault, fault_nxt;
    logic             locked;
    logic             tick;
    logic [CNT_W-1:0] half_period;
    state_t           state, state_nxt;

    assign rise      = s2 & ~s3;
    assign slow_edge = s2 ^ s3;
    assign meas      = cnt + CNT_W'(1);
    assign good      = (meas >= HALF_LO) && (meas <= HALF_HI);
    // An edge cycle always clears cnt, so the edge takes precedence over timeout.
    assign timeout   = !slow_edge && (cnt == CNT_MAX);
    assign run_inc   = run + RUN_W'(1);

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        fault_nxt = fault;
        case (state)
            SEARCH, LOST: begin
                // First edge after idle has no valid start point; it is not judged.
                if (slow_edge) begin
                    state_nxt = ACQUIRE;
                    run_nxt   = '0;
                end
            end
            ACQUIRE: begin
                if (slow_edge) begin
                    if (good) begin
                        if (run_inc == LOCK_RUN) begin
                            state_nxt = LOCK;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    run_nxt   = '0;
                    fault_nxt = 1'b1;
                end
            end
            LOCK: begin
                if (slow_edge) begin
                    if (!good) begin
                        state_nxt = ACQUIRE;
                        run_nxt   = '0;
                        fault_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    run_nxt   = '0;
                    fault_nxt = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            tick        <= 1'b0;
            cnt         <= '0;
            half_period <= '0;
            run         <= '0;
            fault       <= 1'b0;
            locked      <= 1'b0;
            state       <= SEARCH;
        end else begin
            s1   <= SLOW_IN;
            s2   <= s1;
            s3   <= s2;
            tick <= rise;
            if (slow_edge) begin
                half_period <= meas;
                cnt         <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= meas;
            end
            run    <= run_nxt;
            fault  <= fault_nxt;
            locked <= (state_nxt == LOCK);
            state  <= state_nxt;
        end
    end

    assign TICK        = tick;
    assign HALF_PERIOD = half_period;
    assign LOCKED      = locked;
    assign FAULT       = fault;
    assign STATE       = state;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor: vector table of half-periods with expected status,
// plus hand sequences for reset, timeout and tick shape.
module tb_slow_clock_monitor;

    logic       CLOCK_50;
    logic       RESET;
    logic       SLOW_IN;
    logic       TICK;
    logic [7:0] HALF_PERIOD;
    logic       LOCKED;
    logic       FAULT;
    logic [1:0] STATE;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rises  = 0;
    int unsigned ticks  = 0;
    int unsigned cyc    = 0;
    int unsigned last_tick_cyc = 0;
    int unsigned last_delta    = 0;
    logic        tick_q = 1'b0;

    slow_clock_monitor #(
        .EXPECT_HALF(10),
        .TOL(1),
        .LOCK_N(4),
        .TIMEOUT(20),
        .CNT_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .SLOW_IN(SLOW_IN),
        .TICK(TICK),
        .HALF_PERIOD(HALF_PERIOD),
        .LOCKED(LOCKED),
        .FAULT(FAULT),
        .STATE(STATE)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        int unsigned n;
        logic        chk_half;
        logic [7:0]  half;
        logic [1:0]  state;
        logic        locked;
        logic        fault;
    } vec_t;

    vec_t vecs [0:26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tick"},   32'(TICK),        32'd0);
        check({tag, "_half"},   32'(HALF_PERIOD), 32'd0);
        check({tag, "_locked"}, 32'(LOCKED),      32'd0);
        check({tag, "_fault"},  32'(FAULT),       32'd0);
        check({tag, "_state"},  32'(STATE),       32'd0);
    endtask

    // Toggle SLOW_IN, then hold it for n cycles; the edge's effect lands 3 cycles in.
    task automatic half(input int unsigned n);
        SLOW_IN = ~SLOW_IN;
        if (SLOW_IN && RESET) rises++;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic run_vecs(input int unsigned lo, input int unsigned hi);
        for (int unsigned i = lo; i <= hi; i++) begin
            half(vecs[i].n);
            if (vecs[i].chk_half)
                check($sformatf("v%0d_half", i + 1), 32'(HALF_PERIOD), 32'(vecs[i].half));
            check($sformatf("v%0d_state", i + 1),  32'(STATE),  32'(vecs[i].state));
            check($sformatf("v%0d_locked", i + 1), 32'(LOCKED), 32'(vecs[i].locked));
            check($sformatf("v%0d_fault", i + 1),  32'(FAULT),  32'(vecs[i].fault));
        end
    endtask

    always @(negedge CLOCK_50) begin
        cyc++;
        if (TICK === 1'b1) begin
            check("tick_width", 32'(tick_q), 32'd0);
            ticks++;
            last_delta    = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
        end
        tick_q = TICK;
    end

    initial begin
        // n, chk_half, expected HALF_PERIOD (previous interval), STATE, LOCKED, FAULT
        vecs[0]  = '{10, 1'b1, 8'd20, 2'd1, 1'b0, 1'b0};
        vecs[1]  = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{12, 1'b1, 8'd10, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{10, 1'b1, 8'd12, 2'd1, 1'b0, 1'b1};
        vecs[8]  = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[9]  = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[10] = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[11] = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b1};
        vecs[12] = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b1};
        vecs[13] = '{10, 1'b1, 8'd20, 2'd1, 1'b0, 1'b1};
        vecs[14] = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[15] = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[16] = '{10, 1'b1, 8'd10, 2'd1, 1'b0, 1'b1};
        vecs[17] = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b1};
        vecs[18] = '{9,  1'b0, 8'd0,  2'd1, 1'b0, 1'b0};
        vecs[19] = '{9,  1'b1, 8'd9,  2'd1, 1'b0, 1'b0};
        vecs[20] = '{11, 1'b1, 8'd9,  2'd1, 1'b0, 1'b0};
        vecs[21] = '{8,  1'b1, 8'd11, 2'd1, 1'b0, 1'b0};
        vecs[22] = '{10, 1'b1, 8'd8,  2'd1, 1'b0, 1'b0};
        vecs[23] = '{11, 1'b1, 8'd10, 2'd1, 1'b0, 1'b0};
        vecs[24] = '{9,  1'b1, 8'd11, 2'd1, 1'b0, 1'b0};
        vecs[25] = '{10, 1'b1, 8'd9,  2'd1, 1'b0, 1'b0};
        vecs[26] = '{10, 1'b1, 8'd10, 2'd2, 1'b1, 1'b0};

        RESET   = 1'b0;
        SLOW_IN = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            check_idle($sformatf("rst%0d", i));
            SLOW_IN = ~SLOW_IN;
        end
        RESET = 1'b1;

        repeat (25) @(negedge CLOCK_50);
        check("search_idle_state", 32'(STATE), 32'd0);
        check("search_idle_half",  32'(HALF_PERIOD), 32'd0);

        run_vecs(0, 5);
        check("tick_spacing", last_delta, 32'd20);

        run_vecs(6, 12);

        repeat (12) @(negedge CLOCK_50);
        check("pre_timeout_state", 32'(STATE), 32'd2);
        @(negedge CLOCK_50);
        check("timeout_state",  32'(STATE),  32'd3);
        check("timeout_locked", 32'(LOCKED), 32'd0);
        check("timeout_fault",  32'(FAULT),  32'd1);
        repeat (5) @(negedge CLOCK_50);
        check("lost_hold_state", 32'(STATE), 32'd3);

        run_vecs(13, 17);

        RESET = 1'b0;
        @(negedge CLOCK_50);
        RESET = 1'b1;
        check_idle("midrst");
        repeat (5) @(negedge CLOCK_50);
        check("midrst_idle_state", 32'(STATE), 32'd0);

        run_vecs(18, 26);

        check("tick_count", ticks, rises);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
